// File: rtl/multi_phase_traffic_controller.sv
// N-approach round-robin signal controller with per-approach emergency preemption and next-green buzzer.
// Requests take effect one cycle after they are sampled; there is no backpressure, and outputs decode registered state only.
module multi_phase_traffic_controller #(
    parameter int NUM_PHASES  = 2,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int EMERG_TIME  = 10,
    parameter int WARN_TIME   = 5,
    parameter int TIMER_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PHASES-1:0]         emerg_req,
    output logic [2*NUM_PHASES-1:0]       light,
    output logic [NUM_PHASES-1:0]         buzzer,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          emerg_active
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [TIMER_W-1:0] G_LD   = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] Y_LD   = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] A_LD   = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] E_LD   = TIMER_W'(EMERG_TIME - 1);
    localparam logic [TIMER_W:0]   WARN_V = (TIMER_W+1)'(WARN_TIME);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_EGREEN} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [TIMER_W-1:0]    tmr_q, tmr_d;
    logic [NUM_PHASES-1:0] pend_q, pend_d;
    logic [PW-1:0]         tgt, nxt;
    logic [NUM_PHASES-1:0] act_oh, tgt_oh, nxt_oh, req_lat, clr;
    logic                  tmr_done, any_pend, buz_en;

    assign tmr_done = (tmr_q == '0);
    assign any_pend = (pend_q != '0);

    // Lowest-index pending approach wins; scan high to low so the last write is the lowest.
    always_comb begin
        tgt = '0;
        for (int p = NUM_PHASES - 1; p >= 0; p--) begin
            if (pend_q[p]) tgt = PW'(p);
        end
    end

    assign nxt = any_pend ? tgt :
                 (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

    always_comb begin
        act_oh = '0;
        tgt_oh = '0;
        nxt_oh = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            act_oh[p] = (phase_q == PW'(p));
            tgt_oh[p] = (tgt == PW'(p));
            nxt_oh[p] = (nxt == PW'(p));
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmr_d   = tmr_q - TIMER_W'(1);
        req_lat = emerg_req;
        clr     = '0;
        case (state_q)
            S_GREEN: begin
                if ((pend_q & act_oh) != '0) begin
                    state_d = S_EGREEN;
                    tmr_d   = E_LD;
                    clr     = act_oh;
                end else if (any_pend || tmr_done) begin
                    state_d = S_YELLOW;
                    tmr_d   = Y_LD;
                end
            end
            S_YELLOW: begin
                if (tmr_done) begin
                    state_d = S_ALLRED;
                    tmr_d   = A_LD;
                end
            end
            S_ALLRED: begin
                if (tmr_done) begin
                    if (any_pend) begin
                        phase_d = tgt;
                        state_d = S_EGREEN;
                        tmr_d   = E_LD;
                        clr     = tgt_oh;
                    end else begin
                        phase_d = nxt;
                        state_d = S_GREEN;
                        tmr_d   = G_LD;
                    end
                end
            end
            S_EGREEN: begin
                // A repeat request from the served approach extends its green instead of queueing.
                req_lat = emerg_req & ~act_oh;
                if ((emerg_req & act_oh) != '0) begin
                    tmr_d = E_LD;
                end else if (tmr_done) begin
                    state_d = S_YELLOW;
                    tmr_d   = Y_LD;
                end
            end
            default: begin
                state_d = S_GREEN;
                tmr_d   = G_LD;
            end
        endcase
        pend_d = (pend_q | req_lat) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GREEN;
            phase_q <= '0;
            tmr_q   <= G_LD;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
        end
    end

    assign buz_en = ((state_q == S_GREEN) && !any_pend && ({1'b0, tmr_q} < WARN_V)) ||
                    (state_q == S_YELLOW) || (state_q == S_ALLRED);

    always_comb begin
        light = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (act_oh[p]) begin
                if (state_q == S_GREEN || state_q == S_EGREEN) light[2*p +: 2] = 2'b01;
                else if (state_q == S_YELLOW)                  light[2*p +: 2] = 2'b10;
            end
        end
    end

    assign buzzer       = buz_en ? nxt_oh : '0;
    assign active_phase = phase_q;
    assign emerg_active = (state_q == S_EGREEN);
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for the 3-approach controller: normal rotation, emergencies, buzzer and async reset.
module tb_multi_phase_traffic_controller;
    logic       clk;
    logic       rst_n;
    logic [2:0] emerg_req;
    logic [5:0] light;
    logic [2:0] buzzer;
    logic [1:0] active_phase;
    logic       emerg_active;

    int checks = 0;
    int errors = 0;

    multi_phase_traffic_controller #(
        .NUM_PHASES(3), .GREEN_TIME(4), .YELLOW_TIME(2), .ALLRED_TIME(1),
        .EMERG_TIME(3), .WARN_TIME(2), .TIMER_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .emerg_req(emerg_req), .light(light),
        .buzzer(buzzer), .active_phase(active_phase), .emerg_active(emerg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] gl(input int p);
        logic [5:0] v;
        v = 6'b000001;
        return v << (2 * p);
    endfunction

    function automatic logic [5:0] yl(input int p);
        logic [5:0] v;
        v = 6'b000010;
        return v << (2 * p);
    endfunction

    function automatic logic [2:0] bz(input int p);
        logic [2:0] v;
        v = 3'b001;
        return v << p;
    endfunction

    task automatic chk(input string tag, input logic [5:0] l, input logic [2:0] b,
                       input logic [1:0] ap, input logic ea);
        logic [11:0] obs, exp;
        obs = {light, buzzer, active_phase, emerg_active};
        exp = {l, b, ap, ea};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed light/buz/ph/em=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                   tag, light, buzzer, active_phase, emerg_active, l, b, ap, ea);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] l, input logic [2:0] b,
                        input logic [1:0] ap, input logic ea);
        @(posedge clk);
        #1;
        chk(tag, l, b, ap, ea);
    endtask

    // One full normal phase p from its first green cycle through all-red.
    task automatic run_phase(input int p);
        int nx;
        nx = (p + 1) % 3;
        step("norm_g", gl(p), 3'b000, 2'(p), 1'b0);
        step("norm_g", gl(p), 3'b000, 2'(p), 1'b0);
        step("norm_gw", gl(p), bz(nx), 2'(p), 1'b0);
        step("norm_gw", gl(p), bz(nx), 2'(p), 1'b0);
        step("norm_y", yl(p), bz(nx), 2'(p), 1'b0);
        step("norm_y", yl(p), bz(nx), 2'(p), 1'b0);
        step("norm_ar", 6'b0, bz(nx), 2'(p), 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        emerg_req = 3'b000;
        #22;
        chk("reset", gl(0), 3'b000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Normal rotation 0 -> 1 -> 2 -> 0
        step("t1_g0", gl(0), 3'b000, 2'd0, 1'b0);
        step("t1_g0w", gl(0), bz(1), 2'd0, 1'b0);
        step("t1_g0w", gl(0), bz(1), 2'd0, 1'b0);
        step("t1_y0", yl(0), bz(1), 2'd0, 1'b0);
        step("t1_y0", yl(0), bz(1), 2'd0, 1'b0);
        step("t1_ar0", 6'b0, bz(1), 2'd0, 1'b0);
        run_phase(1);
        run_phase(2);
        step("t1_wrap", gl(0), 3'b000, 2'd0, 1'b0);

        // Cross-approach emergency for approach 2
        emerg_req = 3'b100;
        step("t2_g0", gl(0), 3'b000, 2'd0, 1'b0);
        emerg_req = 3'b000;
        step("t2_y0", yl(0), bz(2), 2'd0, 1'b0);
        step("t2_y0", yl(0), bz(2), 2'd0, 1'b0);
        step("t2_ar", 6'b0, bz(2), 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) step("t2_eg2", gl(2), 3'b000, 2'd2, 1'b1);
        step("t2_y2", yl(2), bz(0), 2'd2, 1'b0);
        step("t2_y2", yl(2), bz(0), 2'd2, 1'b0);
        step("t2_ar2", 6'b0, bz(0), 2'd2, 1'b0);
        step("t2_g0", gl(0), 3'b000, 2'd0, 1'b0);

        // Same-approach emergency with mid-green extension
        emerg_req = 3'b001;
        step("t3_g0", gl(0), 3'b000, 2'd0, 1'b0);
        emerg_req = 3'b000;
        step("t3_eg0", gl(0), 3'b000, 2'd0, 1'b1);
        step("t3_eg0", gl(0), 3'b000, 2'd0, 1'b1);
        emerg_req = 3'b001;
        step("t3_ext", gl(0), 3'b000, 2'd0, 1'b1);
        emerg_req = 3'b000;
        step("t3_ext", gl(0), 3'b000, 2'd0, 1'b1);
        step("t3_ext", gl(0), 3'b000, 2'd0, 1'b1);
        step("t3_y0", yl(0), bz(1), 2'd0, 1'b0);
        step("t3_y0", yl(0), bz(1), 2'd0, 1'b0);
        step("t3_ar0", 6'b0, bz(1), 2'd0, 1'b0);
        step("t3_g1", gl(1), 3'b000, 2'd1, 1'b0);

        // Simultaneous requests 1 and 2 during approach 1 green
        emerg_req = 3'b110;
        step("t4_g1", gl(1), 3'b000, 2'd1, 1'b0);
        emerg_req = 3'b000;
        for (int i = 0; i < 3; i++) step("t4_eg1", gl(1), 3'b000, 2'd1, 1'b1);
        step("t4_y1", yl(1), bz(2), 2'd1, 1'b0);
        step("t4_y1", yl(1), bz(2), 2'd1, 1'b0);
        step("t4_ar1", 6'b0, bz(2), 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) step("t4_eg2", gl(2), 3'b000, 2'd2, 1'b1);
        step("t4_y2", yl(2), bz(0), 2'd2, 1'b0);
        step("t4_y2", yl(2), bz(0), 2'd2, 1'b0);
        step("t4_ar2", 6'b0, bz(0), 2'd2, 1'b0);
        step("t4_g0", gl(0), 3'b000, 2'd0, 1'b0);

        // Buzzer redirects from approach 1 to the pending approach 2
        step("t5_g0", gl(0), 3'b000, 2'd0, 1'b0);
        step("t5_g0w", gl(0), bz(1), 2'd0, 1'b0);
        emerg_req = 3'b100;
        step("t5_sup", gl(0), 3'b000, 2'd0, 1'b0);
        emerg_req = 3'b000;
        step("t5_y0", yl(0), bz(2), 2'd0, 1'b0);
        step("t5_y0", yl(0), bz(2), 2'd0, 1'b0);
        step("t5_ar0", 6'b0, bz(2), 2'd0, 1'b0);
        step("t5_eg2", gl(2), 3'b000, 2'd2, 1'b1);
        emerg_req = 3'b010;
        step("t5_eg2", gl(2), 3'b000, 2'd2, 1'b1);
        emerg_req = 3'b000;

        // Async reset between edges mid-emergency; queued request must be dropped
        #3 rst_n = 1'b0;
        #1 chk("t6_rst", gl(0), 3'b000, 2'd0, 1'b0);
        #2 rst_n = 1'b1;
        step("t6_g0", gl(0), 3'b000, 2'd0, 1'b0);
        step("t6_g0w", gl(0), bz(1), 2'd0, 1'b0);
        step("t6_g0w", gl(0), bz(1), 2'd0, 1'b0);
        step("t6_y0", yl(0), bz(1), 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
